// File: rtl/hdc_pkg.sv
// Shared types and width helpers for the hyperdimensional classifier datapath.
package hdc_pkg;

   typedef enum logic [1:0] {
      HVEC_READ       = 2'd0,
      HVEC_WRITE      = 2'd1,
      HVEC_XOR_UPDATE = 2'd2,
      HVEC_ILLEGAL    = 2'd3
   } hvec_op_e;

   typedef enum logic [1:0] {
      CMEM_IDLE  = 2'd0,
      CMEM_READ  = 2'd1,
      CMEM_WRITE = 2'd2
   } cmem_state_e;

   function automatic int unsigned class_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned frame_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/class_hvec_bank.sv
// Class hypervector register array: one write port (overwrite or XOR), one registered read port.
module class_hvec_bank
   import hdc_pkg::*;
#(
   parameter int unsigned DI_PARALLEL_W_BITS = 64,
   parameter int unsigned NUM_CLASSES        = 8,
   parameter int unsigned NUM_FRAMES         = 3
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  wr_en_i,
   input  logic                                  wr_xor_i,
   input  logic [class_w(NUM_CLASSES)-1:0]       wr_class_i,
   input  logic [frame_w(NUM_FRAMES)-1:0]        wr_frame_i,
   input  logic [DI_PARALLEL_W_BITS-1:0]         wr_data_i,
   input  logic [class_w(NUM_CLASSES)-1:0]       rd_class_i,
   input  logic [frame_w(NUM_FRAMES)-1:0]        rd_frame_i,
   output logic [DI_PARALLEL_W_BITS-1:0]         rd_data_o
);

   logic [DI_PARALLEL_W_BITS-1:0] mem_q [NUM_CLASSES][NUM_FRAMES];
   logic [DI_PARALLEL_W_BITS-1:0] rd_data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
            for (int unsigned f = 0; f < NUM_FRAMES; f++) begin
               mem_q[c][f] <= '0;
            end
         end
      end else if (wr_en_i) begin
         mem_q[wr_class_i][wr_frame_i] <= wr_xor_i ? (mem_q[wr_class_i][wr_frame_i] ^ wr_data_i)
                                                   : wr_data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= mem_q[rd_class_i][rd_frame_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/class_hvec_mem.sv
// Trainable class hypervector store: command FSM, frame counter and stream handshakes around the bank.
module class_hvec_mem
   import hdc_pkg::*;
#(
   parameter int unsigned DI_PARALLEL_W_BITS = 64,
   parameter int unsigned NUM_CLASSES        = 8,
   parameter int unsigned NUM_FRAMES         = 3
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  cmd_valid,
   output logic                                  cmd_ready,
   input  logic [1:0]                            cmd_op,
   input  logic [class_w(NUM_CLASSES)-1:0]       cmd_class,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [DI_PARALLEL_W_BITS-1:0]         in_data,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [DI_PARALLEL_W_BITS-1:0]         out_data,
   output logic [frame_w(NUM_FRAMES)-1:0]        out_frame_index,
   output logic                                  out_last,
   output logic                                  cmd_err
);

   localparam int unsigned CLASS_W = class_w(NUM_CLASSES);
   localparam int unsigned FRAME_W = frame_w(NUM_FRAMES);
   localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);

   cmem_state_e          state_q, state_d;
   logic [CLASS_W-1:0]   class_q, class_d;
   logic [FRAME_W-1:0]   frame_q, frame_d;
   logic                 xor_q, xor_d;
   logic                 err_q, err_d;

   logic                 wr_en;
   logic [CLASS_W-1:0]   rd_class;
   logic [FRAME_W-1:0]   rd_frame;
   logic [DI_PARALLEL_W_BITS-1:0] rd_data;
   logic                 frame_last;
   logic                 cmd_illegal;
   hvec_op_e             op;

   assign op          = hvec_op_e'(cmd_op);
   assign frame_last  = (frame_q == LAST_FRAME);
   assign cmd_illegal = (op == HVEC_ILLEGAL) || (32'(cmd_class) >= NUM_CLASSES);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CMEM_IDLE;
         class_q <= '0;
         frame_q <= '0;
         xor_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         class_q <= class_d;
         frame_q <= frame_d;
         xor_q   <= xor_d;
         err_q   <= err_d;
      end
   end

   // The read address runs one beat ahead so the registered bank output lines up with frame_q.
   always_comb begin
      state_d   = state_q;
      class_d   = class_q;
      frame_d   = frame_q;
      xor_d     = xor_q;
      err_d     = 1'b0;
      cmd_ready = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      wr_en     = 1'b0;
      rd_class  = class_q;
      rd_frame  = frame_q;
      case (state_q)
         CMEM_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               if (cmd_illegal) begin
                  err_d = 1'b1;
               end else begin
                  class_d = cmd_class;
                  frame_d = '0;
                  xor_d   = (op == HVEC_XOR_UPDATE);
                  if (op == HVEC_READ) begin
                     state_d  = CMEM_READ;
                     rd_class = cmd_class;
                     rd_frame = '0;
                  end else begin
                     state_d = CMEM_WRITE;
                  end
               end
            end
         end
         CMEM_READ: begin
            out_valid = 1'b1;
            if (out_ready) begin
               if (frame_last) begin
                  state_d = CMEM_IDLE;
                  frame_d = '0;
               end else begin
                  frame_d  = frame_q + 1'b1;
                  rd_frame = frame_q + 1'b1;
               end
            end
         end
         CMEM_WRITE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               wr_en = 1'b1;
               if (frame_last) begin
                  state_d = CMEM_IDLE;
                  frame_d = '0;
               end else begin
                  frame_d = frame_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = CMEM_IDLE;
            frame_d = '0;
         end
      endcase
   end

   class_hvec_bank #(
      .DI_PARALLEL_W_BITS (DI_PARALLEL_W_BITS),
      .NUM_CLASSES        (NUM_CLASSES),
      .NUM_FRAMES         (NUM_FRAMES)
   ) u_bank (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en_i    (wr_en),
      .wr_xor_i   (xor_q),
      .wr_class_i (class_q),
      .wr_frame_i (frame_q),
      .wr_data_i  (in_data),
      .rd_class_i (rd_class),
      .rd_frame_i (rd_frame),
      .rd_data_o  (rd_data)
   );

   assign out_data        = out_valid ? rd_data : '0;
   assign out_frame_index = out_valid ? frame_q : '0;
   assign out_last        = out_valid && frame_last;
   assign cmd_err         = err_q;

endmodule

// File: tb/tb_class_hvec_mem.sv
// Randomised scoreboard bench for class_hvec_mem against an array-based reference store.
module tb_class_hvec_mem;
   import hdc_pkg::*;

   localparam int W  = 64;
   localparam int NC = 6;
   localparam int NF = 3;
   localparam int CW = 3;
   localparam int FW = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = '0;
   logic [CW-1:0] cmd_class = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  out_data;
   logic [FW-1:0] out_frame_index;
   logic          out_last;
   logic          cmd_err;

   class_hvec_mem #(
      .DI_PARALLEL_W_BITS (W),
      .NUM_CLASSES        (NC),
      .NUM_FRAMES         (NF)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_op          (cmd_op),
      .cmd_class       (cmd_class),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_data         (in_data),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_data        (out_data),
      .out_frame_index (out_frame_index),
      .out_last        (out_last),
      .cmd_err         (cmd_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0]  data;
      logic [FW-1:0] idx;
      logic          last;
   } beat_t;

   beat_t        exp_q[$];
   logic [W-1:0] ref_mem [NC][NF];
   int           checks = 0;
   int           errors = 0;
   int           ready_mode = 0;
   int           pat = 0;
   bit           ones_data = 0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_ref();
      for (int c = 0; c < NC; c++)
         for (int f = 0; f < NF; f++)
            ref_mem[c][f] = '0;
      exp_q.delete();
   endtask

   // out_ready generator: 0 tied high, 1 random, 2 repeating 1,0,0
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0: out_ready = 1'b1;
         1: out_ready = 1'($urandom_range(0, 1));
         default: begin
            out_ready = (pat % 3 == 0);
            pat++;
         end
      endcase
   end

   // Monitor: pops the scoreboard on each output handshake, checks hold during stalls.
   beat_t held;
   bit    stalled = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         stalled = 0;
      end else begin
         check("vld_rdy_excl", {63'b0, out_valid && in_ready}, '0);
         if (stalled) begin
            check("stall_valid", {63'b0, out_valid}, 64'd1);
            check("stall_data", out_data, held.data);
            check("stall_idx_last", {61'b0, out_frame_index, out_last}, {61'b0, held.idx, held.last});
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", {63'b0, out_valid}, '0);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               check("beat_data", out_data, e.data);
               check("beat_idx", {62'b0, out_frame_index}, {62'b0, e.idx});
               check("beat_last", {63'b0, out_last}, {63'b0, e.last});
            end
         end
         stalled = out_valid && !out_ready;
         held    = '{data: out_data, idx: out_frame_index, last: out_last};
      end
   end

   task automatic do_cmd(input logic [1:0] op, input int cls);
      bit           illegal;
      int           n;
      int           cyc;
      logic [W-1:0] d;
      illegal = (op == 2'd3) || (cls >= NC);
      n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("cmd_ready_wait", {63'b0, cmd_ready}, 64'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_class = CW'(cls);
      if (!illegal && op == 2'd0)
         for (int f = 0; f < NF; f++)
            exp_q.push_back('{data: ref_mem[cls][f], idx: FW'(f), last: (f == NF - 1)});
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      check("cmd_err_pulse", {63'b0, cmd_err}, {63'b0, illegal});
      check("out_valid_start", {63'b0, out_valid}, {63'b0, !illegal && op == 2'd0});
      check("in_ready_start", {63'b0, in_ready}, {63'b0, !illegal && op != 2'd0});
      if (illegal) begin
         @(negedge clk);
         check("cmd_err_drop", {63'b0, cmd_err}, '0);
         check("illegal_idle", {62'b0, cmd_ready, out_valid}, 64'd2);
      end else if (op == 2'd0) begin
         cyc = 1;
         while (!(out_valid && out_ready && out_last) && cyc < 200) begin
            @(negedge clk);
            cyc++;
         end
         if (ready_mode == 0) check("read_burst_len", 64'(cyc), 64'(NF));
         @(negedge clk);
         check("read_done_ready", {62'b0, cmd_ready, out_valid}, 64'd2);
         check("scoreboard_empty", 64'(exp_q.size()), '0);
      end else begin
         for (int f = 0; f < NF; f++) begin
            d = ones_data ? '1 : {$urandom, $urandom};
            ref_mem[cls][f] = (op == 2'd2) ? (ref_mem[cls][f] ^ d) : d;
            n = $urandom_range(0, 2);
            repeat (n) @(negedge clk);
            in_valid = 1'b1;
            in_data  = d;
            @(posedge clk);
            #1 in_valid = 1'b0;
            @(negedge clk);
         end
         check("write_done_ready", {62'b0, cmd_ready, in_ready}, 64'd2);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_ref();
      repeat (2) @(negedge clk);
      check("reset_outputs", {60'b0, out_valid, in_ready, out_last, cmd_err}, '0);
      check("reset_data", out_data, '0);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_ready", {63'b0, cmd_ready}, 64'd1);

      ready_mode = 0;
      do_cmd(2'd0, 5);
      do_cmd(2'd1, 3);
      do_cmd(2'd0, 3);
      do_cmd(2'd0, 2);
      ones_data = 1;
      do_cmd(2'd2, 3);
      ones_data = 0;
      do_cmd(2'd0, 3);
      ready_mode = 2;
      pat = 0;
      do_cmd(2'd0, 3);
      ready_mode = 0;
      do_cmd(2'd3, 0);
      do_cmd(2'd0, 7);
      do_cmd(2'd1, 6);
      do_cmd(2'd0, 3);

      // Reset during the second beat of a WRITE to class 1
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 2'd1;
      cmd_class = 3'd1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      @(posedge clk);
      #1 in_data = {$urandom, $urandom};
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      in_valid = 1'b0;
      clear_ref();
      @(negedge clk);
      check("mid_reset_idle", {60'b0, cmd_ready, in_ready, out_valid, cmd_err}, 64'd8);
      do_cmd(2'd0, 1);
      do_cmd(2'd0, 3);

      for (int i = 0; i < 60; i++) begin
         ready_mode = $urandom_range(0, 2);
         do_cmd(2'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
      end
      ready_mode = 0;
      for (int c = 0; c < NC; c++) do_cmd(2'd0, c);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
